joy_port: RTL and testbench

JOY_PORT -- requirements
Module: joy_port

---
 rtl/joy_pkg.sv | 47 ++++
 rtl/joy_filter.sv | 76 +++++++
 rtl/joy_port.sv | 77 +++++++
 tb/tb_joy_port.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared pad bit layout, Kempston bit positions and Sinclair row column map
// for the joystick port block.
package joy_pkg;

    localparam int PAD_W = 6;

    localparam int RIGHT = 0;
    localparam int LEFT  = 1;
    localparam int DOWN  = 2;
    localparam int UP    = 3;
    localparam int FIRE1 = 4;
    localparam int FIRE2 = 5;

    localparam int KEMP_RIGHT = 0;
    localparam int KEMP_LEFT  = 1;
    localparam int KEMP_DOWN  = 2;
    localparam int KEMP_UP    = 3;
    localparam int KEMP_FIRE  = 4;

    // Sinclair joystick sits on keyboard row EFFE (address bit 12 -> a[4]).
    localparam int SINCLAIR_ROW_BIT = 4;
    localparam int COL_FIRE  = 0;
    localparam int COL_UP    = 1;
    localparam int COL_DOWN  = 2;
    localparam int COL_RIGHT = 3;
    localparam int COL_LEFT  = 4;

    typedef struct packed {
        logic fire;
        logic up;
        logic down;
        logic left;
        logic right;
    } cleanPad_t;

    // Opposing directions pressed together cancel each other out.
    function automatic cleanPad_t socdClean(input logic [PAD_W-1:0] vec, input logic fire);
        cleanPad_t p;
        p.fire  = fire;
        p.right = vec[RIGHT] & ~vec[LEFT];
        p.left  = vec[LEFT]  & ~vec[RIGHT];
        p.up    = vec[UP]    & ~vec[DOWN];
        p.down  = vec[DOWN]  & ~vec[UP];
        return p;
    endfunction

endpackage

// File: rtl/joy_filter.sv
// One pad: whole-vector debounce plus fire-button merge. Autofire on fire2
// is built only when JOY_AUTOFIRE_EN is defined.
module joy_filter
    import joy_pkg::*;
#(
    parameter int DEBOUNCE  = 4,
    parameter int AF_PERIOD = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic [PAD_W-1:0] raw,
    output logic [PAD_W-1:0] stable,
    output logic             fire
);

    logic [3:0] count;
    logic       match;
    logic       loadNow;

    assign match   = (raw == stable);
    assign loadNow = ce && !match && (count == 4'(DEBOUNCE - 1));

    // Count tracks how long raw has disagreed with stable, not raw-to-raw changes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stable <= '0;
            count  <= '0;
        end else if (ce) begin
            if (match) begin
                count <= '0;
            end else if (count == 4'(DEBOUNCE - 1)) begin
                stable <= raw;
                count  <= '0;
            end else begin
                count <= count + 4'd1;
            end
        end
    end

`ifdef JOY_AUTOFIRE_EN
    logic [PAD_W-1:0] stableNext;
    logic [7:0]       afCount;
    logic             phase;

    assign stableNext = loadNow ? raw : stable;

    // Rising edge of the debounced fire2 starts a fresh "pressed" half-period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            afCount <= '0;
            phase   <= 1'b0;
        end else if (ce) begin
            if (!stableNext[FIRE2]) begin
                afCount <= '0;
                phase   <= 1'b0;
            end else if (!stable[FIRE2]) begin
                afCount <= '0;
                phase   <= 1'b1;
            end else if (afCount == 8'(AF_PERIOD - 1)) begin
                afCount <= '0;
                phase   <= ~phase;
            end else begin
                afCount <= afCount + 8'd1;
            end
        end
    end

    assign fire = stable[FIRE1] | phase;
`else
    logic unusedLoad;
    assign unusedLoad = loadNow;
    assign fire       = stable[FIRE1] | stable[FIRE2];
`endif

endmodule

// File: rtl/joy_port.sv
// Two debounced pads mapped onto the Kempston port and the Sinclair keyboard
// row. Optional autofire on fire2: define JOY_AUTOFIRE_EN.
module joy_port
    import joy_pkg::*;
#(
    parameter int DEBOUNCE  = 4,
    parameter int AF_PERIOD = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] joy1,
    input  logic [7:0] joy2,
    input  logic       swap,
    input  logic [7:0] a,
    output logic [7:0] kempston,
    output logic [4:0] keyCols
);

    logic [PAD_W-1:0] stable1, stable2;
    logic             fire1, fire2;
    cleanPad_t        clean1, clean2, kempPad, sincPad;
    logic [7:0]       kempNext;
    logic             unusedBits;

    assign unusedBits = ^{joy1[7:6], joy2[7:6], a[7:5], a[3:0]};

    joy_filter #(.DEBOUNCE(DEBOUNCE), .AF_PERIOD(AF_PERIOD)) pad1Filter (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .raw   (joy1[PAD_W-1:0]),
        .stable(stable1),
        .fire  (fire1)
    );

    joy_filter #(.DEBOUNCE(DEBOUNCE), .AF_PERIOD(AF_PERIOD)) pad2Filter (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .raw   (joy2[PAD_W-1:0]),
        .stable(stable2),
        .fire  (fire2)
    );

    assign clean1  = socdClean(stable1, fire1);
    assign clean2  = socdClean(stable2, fire2);
    assign kempPad = swap ? clean2 : clean1;
    assign sincPad = swap ? clean1 : clean2;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        kempNext             = '0;
        kempNext[KEMP_RIGHT] = kempPad.right;
        kempNext[KEMP_LEFT]  = kempPad.left;
        kempNext[KEMP_DOWN]  = kempPad.down;
        kempNext[KEMP_UP]    = kempPad.up;
        kempNext[KEMP_FIRE]  = kempPad.fire;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) kempston <= 8'h00;
        else        kempston <= kempNext;
    end

    always_comb begin
        keyCols = 5'h1F;
        if (!a[SINCLAIR_ROW_BIT]) begin
            keyCols[COL_FIRE]  = ~sincPad.fire;
            keyCols[COL_UP]    = ~sincPad.up;
            keyCols[COL_DOWN]  = ~sincPad.down;
            keyCols[COL_RIGHT] = ~sincPad.right;
            keyCols[COL_LEFT]  = ~sincPad.left;
        end
    end

endmodule

// File: tb/tb_joy_port.sv
// Directed bench for joy_port: debounce timing, SOCD, Sinclair row mapping,
// swap, fire2 handling (autofire when JOY_AUTOFIRE_EN is defined) and reset.
module tb_joy_port;

    logic       clock;
    logic       reset;
    logic       ce;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic       swap;
    logic [7:0] a;
    logic [7:0] kempston;
    logic [4:0] keyCols;

    int compared   = 0;
    int mismatched = 0;

    joy_port #(.DEBOUNCE(4), .AF_PERIOD(3)) dut (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .joy1    (joy1),
        .joy2    (joy2),
        .swap    (swap),
        .a       (a),
        .kempston(kempston),
        .keyCols (keyCols)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One ce-qualified posedge, ending on the falling edge just after it.
    task automatic pulseCe();
        @(negedge clock);
        ce = 1'b1;
        @(negedge clock);
        ce = 1'b0;
    endtask

    // n ce samples, each followed by one extra clock so kempston has caught up.
    task automatic applyCe(input int n);
        for (int i = 0; i < n; i++) begin
            pulseCe();
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ce = 1'b0; joy1 = 8'h00; joy2 = 8'h00; swap = 1'b0; a = 8'hEF;
        repeat (3) @(negedge clock);
        compared++;
        if (kempston !== 8'h00) begin
            mismatched++; $display("FAIL reset_kempston got=%h want=%h", kempston, 8'h00);
        end
        compared++;
        if (keyCols !== 5'h1F) begin
            mismatched++; $display("FAIL reset_keycols got=%h want=%h", keyCols, 5'h1F);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_debounce();
        joy1 = 8'h01;
        for (int i = 1; i <= 4; i++) begin
            pulseCe();
            if (i == 4) begin
                compared++;
                if (kempston !== 8'h00) begin
                    mismatched++; $display("FAIL debounce_latency got=%h want=%h", kempston, 8'h00);
                end
                @(negedge clock);
                compared++;
                if (kempston !== 8'h01) begin
                    mismatched++; $display("FAIL debounce_accept got=%h want=%h", kempston, 8'h01);
                end
            end else begin
                repeat (3) @(negedge clock);
                compared++;
                if (kempston !== 8'h00) begin
                    mismatched++; $display("FAIL debounce_ce%0d got=%h want=%h", i, kempston, 8'h00);
                end
            end
        end
    endtask

    task automatic test_socd();
        logic [7:0] vin [3] = '{8'h03, 8'h0C, 8'h09};
        logic [7:0] vexp[3] = '{8'h00, 8'h00, 8'h09};
        for (int i = 0; i < 3; i++) begin
            joy1 = vin[i];
            applyCe(4);
            compared++;
            if (kempston !== vexp[i]) begin
                mismatched++;
                $display("FAIL socd_%h got=%h want=%h", vin[i], kempston, vexp[i]);
            end
        end
    endtask

    task automatic test_sinclair();
        logic [7:0] aIn [3] = '{8'hEF, 8'hFE, 8'h00};
        logic [4:0] cExp[3] = '{5'h1C, 5'h1F, 5'h1C};
        joy1 = 8'h00;
        joy2 = 8'h18;
        swap = 1'b0;
        applyCe(4);
        compared++;
        if (kempston !== 8'h00) begin
            mismatched++; $display("FAIL sinclair_kemp_pad1 got=%h want=%h", kempston, 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            a = aIn[i];
            #1;
            compared++;
            if (keyCols !== cExp[i]) begin
                mismatched++;
                $display("FAIL sinclair_a%h got=%h want=%h", aIn[i], keyCols, cExp[i]);
            end
        end
        a = 8'hEF;
        swap = 1'b1;
        #1;
        compared++;
        if (keyCols !== 5'h1F) begin
            mismatched++; $display("FAIL swap_keycols got=%h want=%h", keyCols, 5'h1F);
        end
        compared++;
        if (kempston !== 8'h00) begin
            mismatched++; $display("FAIL swap_kemp_early got=%h want=%h", kempston, 8'h00);
        end
        @(negedge clock);
        compared++;
        if (kempston !== 8'h18) begin
            mismatched++; $display("FAIL swap_kemp got=%h want=%h", kempston, 8'h18);
        end
        swap = 1'b0;
        joy2 = 8'h05;
        applyCe(4);
        compared++;
        if (keyCols !== 5'h13) begin
            mismatched++; $display("FAIL sinclair_right_down got=%h want=%h", keyCols, 5'h13);
        end
        joy2 = 8'h26;
        applyCe(4);
        compared++;
        if (keyCols !== 5'h0A) begin
            mismatched++; $display("FAIL sinclair_left_fire2 got=%h want=%h", keyCols, 5'h0A);
        end
        joy2 = 8'h00;
        applyCe(4);
    endtask

    task automatic test_fire2();
        logic [7:0] want;
        joy1 = 8'h20;
        applyCe(4);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) applyCe(1);
`ifdef JOY_AUTOFIRE_EN
            want = (((k / 3) % 2) == 0) ? 8'h10 : 8'h00;
`else
            want = 8'h10;
`endif
            compared++;
            if (kempston !== want) begin
                mismatched++; $display("FAIL fire2_ce%0d got=%h want=%h", k, kempston, want);
            end
        end
        joy1 = 8'h00;
        applyCe(4);
        compared++;
        if (kempston !== 8'h00) begin
            mismatched++; $display("FAIL fire2_release got=%h want=%h", kempston, 8'h00);
        end
        applyCe(1);
        compared++;
        if (kempston !== 8'h00) begin
            mismatched++; $display("FAIL fire2_release_hold got=%h want=%h", kempston, 8'h00);
        end
    endtask

    task automatic test_chatter();
        for (int i = 0; i < 20; i++) begin
            joy1 = ((i % 2) == 0) ? 8'h01 : 8'h00;
            applyCe(1);
            compared++;
            if (kempston !== 8'h00) begin
                mismatched++; $display("FAIL chatter_ce%0d got=%h want=%h", i, kempston, 8'h00);
            end
        end
        joy1 = 8'h00;
    endtask

    task automatic test_reset_mid();
        joy1 = 8'h09;
        joy2 = 8'h10;
        a    = 8'hEF;
        applyCe(4);
        compared++;
        if (kempston !== 8'h09) begin
            mismatched++; $display("FAIL premid_kemp got=%h want=%h", kempston, 8'h09);
        end
        compared++;
        if (keyCols !== 5'h1E) begin
            mismatched++; $display("FAIL premid_keycols got=%h want=%h", keyCols, 5'h1E);
        end
        joy1 = 8'h01;
        applyCe(2);
        #2 reset = 1'b0;
        #1;
        compared++;
        if (kempston !== 8'h00) begin
            mismatched++; $display("FAIL midreset_kemp got=%h want=%h", kempston, 8'h00);
        end
        compared++;
        if (keyCols !== 5'h1F) begin
            mismatched++; $display("FAIL midreset_keycols got=%h want=%h", keyCols, 5'h1F);
        end
        @(negedge clock);
        reset = 1'b1;
        joy2 = 8'h00;
        applyCe(3);
        compared++;
        if (kempston !== 8'h00) begin
            mismatched++; $display("FAIL postreset_ce3 got=%h want=%h", kempston, 8'h00);
        end
        applyCe(1);
        compared++;
        if (kempston !== 8'h01) begin
            mismatched++; $display("FAIL postreset_ce4 got=%h want=%h", kempston, 8'h01);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_socd();
        test_sinclair();
        test_fire2();
        test_chatter();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
